// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: oversampled UART receiver.
//
// Frame: start bit, DATA_WIDTH data bits LSB first, optional even/odd parity
// bit, one stop bit. Each bit lasts PRESCALE clock cycles. Each bit value is
// the majority of three samples taken around mid-bit.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   synchronous active-high reset
//   RX_IN      in   serial line (idle high), already synchronized to CLK
//   PAR_EN     in   1 = frame carries a parity bit (latched at start of frame)
//   PAR_TYP    in   0 = even, 1 = odd parity (latched at start of frame)
//   P_DATA     out  last correctly received word
//   DATA_VALID out  one-cycle pulse when P_DATA is updated
//   PAR_ERR    out  one-cycle pulse: parity mismatch in the completed frame
//   STP_ERR    out  one-cycle pulse: stop bit sampled low in the completed frame
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int unsigned EW = $clog2(PRESCALE);
    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [EW-1:0] EdgeLast = EW'(PRESCALE - 1);
    localparam logic [EW-1:0] EdgeS0   = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] EdgeS1   = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] EdgeS2   = EW'(PRESCALE / 2 + 1);
    localparam logic [BW-1:0] BitLast  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                state_q, state_d;
    logic [EW-1:0]         edge_q, edge_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [2:0]            samp_q, samp_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_acc_q, par_acc_d;
    logic                  par_fail_q, par_fail_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;

    logic bit_eval;
    logic s2_now;
    logic bit_val;

    // With PRESCALE = 4 the third sample lands on the evaluation cycle itself,
    // so it has to be taken straight from the line rather than from samp_q.
    assign s2_now   = (edge_q == EdgeS2) ? RX_IN : samp_q[2];
    assign bit_val  = (samp_q[0] & samp_q[1]) | (samp_q[0] & s2_now) | (samp_q[1] & s2_now);
    assign bit_eval = (edge_q == EdgeLast);

    always_comb begin
        state_d    = state_q;
        edge_d     = edge_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        samp_d     = samp_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_acc_d  = par_acc_q;
        par_fail_d = par_fail_q;
        p_data_d   = p_data_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;

        // The IDLE cycle that sees the line low is edge 0 of the start bit.
        if (state_q == StIdle) begin
            edge_d = RX_IN ? '0 : EW'(1);
        end else begin
            edge_d = bit_eval ? '0 : edge_q + EW'(1);
            if (edge_q == EdgeS0) samp_d[0] = RX_IN;
            if (edge_q == EdgeS1) samp_d[1] = RX_IN;
            if (edge_q == EdgeS2) samp_d[2] = RX_IN;
        end

        unique case (state_q)
            StIdle: begin
                if (!RX_IN) begin
                    state_d    = StStart;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_acc_d  = 1'b0;
                    par_fail_d = 1'b0;
                    bit_d      = '0;
                end
            end
            StStart: begin
                if (bit_eval) begin
                    // A start bit that votes high was a glitch.
                    if (bit_val) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        bit_d   = '0;
                    end
                end
            end
            StData: begin
                if (bit_eval) begin
                    shift_d   = {bit_val, shift_q[DATA_WIDTH-1:1]};
                    par_acc_d = par_acc_q ^ bit_val;
                    if (bit_q == BitLast) begin
                        state_d = par_en_q ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            StParity: begin
                if (bit_eval) begin
                    par_fail_d = (bit_val != (par_acc_q ^ par_typ_q));
                    state_d    = StStop;
                end
            end
            StStop: begin
                if (bit_eval) begin
                    state_d = StIdle;
                    if (!par_fail_q && bit_val) begin
                        p_data_d = shift_q;
                        dv_d     = 1'b1;
                    end else begin
                        pe_d = par_fail_q;
                        se_d = ~bit_val;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            edge_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            samp_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_acc_q  <= 1'b0;
            par_fail_q <= 1'b0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            samp_q     <= samp_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_acc_q  <= par_acc_d;
            par_fail_q <= par_fail_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = dv_q;
    assign PAR_ERR    = pe_q;
    assign STP_ERR    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx: self-checking bench for uart_rx (DATA_WIDTH=8, PRESCALE=8).
// Expected pulses are queued when a frame is driven and compared by a monitor
// when the DUT pulses any output.
module tb_uart_rx;

    localparam int P  = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic          dv;
        logic          pe;
        logic          se;
        logic [DW-1:0] pdata;
        int            cyc;
    } exp_t;

    exp_t sb[$];

    uart_rx #(
        .DATA_WIDTH(DW),
        .PRESCALE  (P)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .RX_IN     (rx),
        .PAR_EN    (par_en),
        .PAR_TYP   (par_typ),
        .P_DATA    (p_data),
        .DATA_VALID(data_valid),
        .PAR_ERR   (par_err),
        .STP_ERR   (stp_err)
    );

    always #5 clk = ~clk;

    // Cycle number of the clock period currently running.
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every pulse must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (data_valid || par_err || stp_err) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: dv=%b pe=%b se=%b at cycle %0d, required no pulse",
                         data_valid, par_err, stp_err, cyc);
            end else begin
                e = sb.pop_front();
                if ({data_valid, par_err, stp_err} !== {e.dv, e.pe, e.se}) begin
                    errors++;
                    $display("FAIL pulse_kind: dv/pe/se=%b%b%b, required %b%b%b",
                             data_valid, par_err, stp_err, e.dv, e.pe, e.se);
                end
                checks++;
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL pulse_cycle: pulse at cycle %0d, required %0d", cyc, e.cyc);
                end
                checks++;
                if (p_data !== e.pdata) begin
                    errors++;
                    $display("FAIL pulse_pdata: P_DATA=%h, required %h", p_data, e.pdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic b, input int glitch_at);
        for (int j = 0; j < P; j++) begin
            rx = (j == glitch_at) ? ~b : b;
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame starting in the current cycle (t0) and queues the
    // expected pulse. PAR_EN/PAR_TYP are inverted after the start bit to show
    // they are latched.
    task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                              input logic pbit, input logic sbit, input logic edv,
                              input logic epe, input logic ese, input logic [DW-1:0] epd,
                              input int gbit);
        exp_t e;
        int   t0;
        t0      = cyc;
        par_en  = pen;
        par_typ = ptyp;
        if (edv || epe || ese) begin
            e.dv    = edv;
            e.pe    = epe;
            e.se    = ese;
            e.pdata = epd;
            e.cyc   = t0 + (2 + DW + (pen ? 1 : 0)) * P;
            sb.push_back(e);
        end
        drive_bit(1'b0, -1);
        par_en  = ~pen;
        par_typ = ~ptyp;
        for (int i = 0; i < DW; i++) drive_bit(d[i], (i == gbit) ? P / 2 : -1);
        if (pen) drive_bit(pbit, -1);
        drive_bit(sbit, -1);
        rx = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 4 * P) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d pulses still pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx = (i % 2 == 0) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if ({p_data, data_valid, par_err, stp_err} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: P_DATA=%h dv=%b pe=%b se=%b, required all 0",
                         p_data, data_valid, par_err, stp_err);
            end
        end
        rx  = 1'b1;
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if ({p_data, data_valid, par_err, stp_err} !== '0) begin
            errors++;
            $display("FAIL reset_release: P_DATA=%h dv=%b pe=%b se=%b, required all 0",
                     p_data, data_valid, par_err, stp_err);
        end
    endtask

    task automatic test_parity_ok();
        send_frame(8'hD2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hD2, -1);
        wait_drain("parity_even");
        send_frame(8'hD2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hD2, -1);
        wait_drain("parity_odd");
        checks++;
        if (p_data !== 8'hD2) begin
            errors++;
            $display("FAIL parity_ok_pdata: P_DATA=%h, required d2", p_data);
        end
    endtask

    task automatic test_parity_error();
        send_frame(8'hD3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hD2, -1);
        wait_drain("parity_err");
        checks++;
        if (p_data !== 8'hD2) begin
            errors++;
            $display("FAIL parity_err_pdata: P_DATA=%h, required d2", p_data);
        end
    endtask

    task automatic test_back_to_back();
        // Stop bit low, then the next start bit follows with no idle time.
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hD2, -1);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, -1);
        wait_drain("back_to_back");
        checks++;
        if (p_data !== 8'hA5) begin
            errors++;
            $display("FAIL back_to_back_pdata: P_DATA=%h, required a5", p_data);
        end
    endtask

    task automatic test_start_glitch();
        // Low for 2 cycles then high; a frame started at t0+8 proves IDLE by then.
        rx = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h96, -1);
        wait_drain("start_glitch");
    endtask

    task automatic test_data_glitch();
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 3);
        wait_drain("data_glitch_low");
        send_frame(8'h3F, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3F, 3);
        wait_drain("data_glitch_high");
    endtask

    task automatic test_reset_midframe();
        logic [DW-1:0] d;
        d       = 8'h81;
        par_en  = 1'b0;
        par_typ = 1'b0;
        drive_bit(1'b0, -1);
        for (int i = 0; i < 4; i++) drive_bit(d[i], -1);
        rx = d[4];
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        checks++;
        if ({p_data, data_valid, par_err, stp_err} !== '0) begin
            errors++;
            $display("FAIL midframe_reset_outputs: P_DATA=%h dv=%b pe=%b se=%b, required all 0",
                     p_data, data_valid, par_err, stp_err);
        end
        repeat (16) begin
            @(posedge clk);
            #1;
        end
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, -1);
        wait_drain("midframe_reset");
        checks++;
        if (p_data !== 8'h3C) begin
            errors++;
            $display("FAIL midframe_reset_pdata: P_DATA=%h, required 3c", p_data);
        end
    endtask

    initial begin
        test_reset();
        test_parity_ok();
        test_parity_error();
        test_back_to_back();
        test_start_glitch();
        test_data_glitch();
        test_reset_midframe();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the team's UART TX (serializer plus parity_calc).
- Deserializes an oversampled serial line into parallel bytes.
- Frame format: start bit, DATA_WIDTH data bits LSB first, optional even/odd parity bit, one stop bit.
- Reports the received word with a one-cycle valid pulse; flags parity and stop-bit errors.
- Sits between the line synchronizer and the RX FIFO / register block.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.
PRESCALE, 8, CLK cycles per serial bit. Must be even and >= 4.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  synchronous, active-high reset.
RX_IN  input  1  serial line, idle high, already synchronized to CLK.
PAR_EN  input  1  1 = frame carries a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
P_DATA  output  DATA_WIDTH  last correctly received word.
DATA_VALID  output  1  one-cycle pulse when P_DATA is updated.
PAR_ERR  output  1  one-cycle pulse: parity mismatch in the completed frame.
STP_ERR  output  1  one-cycle pulse: stop bit sampled low in the completed frame.

Behaviour:
- Reset (RST=1 at a clock edge):
  - State = IDLE; edge_cnt, bit_cnt and shift register cleared.
  - P_DATA = 0; DATA_VALID = 0; PAR_ERR = 0; STP_ERR = 0.
  - Reset mid-frame aborts the frame silently: no pulses, P_DATA unchanged from its reset value.
- Counters:
  - edge_cnt runs 0..PRESCALE-1 within each bit and wraps to 0 at each bit boundary.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Bit sampling:
  - RX_IN is captured at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
  - The bit value is the majority of those three samples.
  - The bit is evaluated when edge_cnt = PRESCALE-1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - RX_IN=0 -> go to START. That cycle counts as edge_cnt=0 of the start bit.
  - PAR_EN and PAR_TYP are latched in this same cycle and held for the whole frame. Changes mid-frame are ignored.
- START:
  - At edge_cnt=PRESCALE-1: sampled bit 1 -> glitch; go to IDLE with no outputs.
  - Sampled bit 0 -> go to DATA with bit_cnt=0.
- DATA:
  - Each evaluated bit is shifted in LSB first.
  - After bit DATA_WIDTH-1: go to PARITY if latched PAR_EN=1, else go to STOP.
- PARITY:
  - Expected bit = XOR of the received data bits (even), inverted for odd.
  - A mismatch sets an internal par_fail flag. Go to STOP.
- STOP, at edge_cnt=PRESCALE-1:
  - stp_fail = (sampled bit == 0).
  - If no fail flag is set: load P_DATA and pulse DATA_VALID.
  - Otherwise: pulse PAR_ERR and/or STP_ERR and leave P_DATA unchanged.
  - Both error pulses may assert together.
  - Go to IDLE.
- Outputs are registered. Pulses are exactly one cycle wide; DATA_VALID never coincides with either error.
- Latency: t0 = the IDLE cycle in which RX_IN is first seen low. N = 2 + DATA_WIDTH + PAR_EN. The DATA_VALID / error pulse is high in cycle t0 + N*PRESCALE.
- Back-to-back frames:
  - A start bit beginning in the cycle after STOP completes is detected normally.
  - No idle time is required between frames.
- Line held low after a framing error: the receiver re-enters START immediately and treats the line as a new start bit.
- RX_IN glitches shorter than 2 samples inside the sampling window are rejected by the majority vote.

Test Plan:
- Reset: hold RST=1 for 3 cycles with RX_IN toggling -> all outputs 0, FSM stays IDLE; release RST with RX_IN=1 -> no pulses.
- 0xD2, PAR_EN=1, PAR_TYP=0, parity bit 0, stop bit 1 -> DATA_VALID pulse at t0+88 (PRESCALE=8, N=11); P_DATA=0xD2; no errors. Repeat with PAR_TYP=1, parity bit 1 -> same result.
- 0xD3, PAR_EN=1, PAR_TYP=0, parity bit 0 (expected 1) -> PAR_ERR pulse at t0+88; no DATA_VALID; P_DATA keeps the previous 0xD2.
- 0x5A, PAR_EN=0, stop bit driven 0 -> STP_ERR pulse at t0+80; no DATA_VALID. Then frame 0xA5 back-to-back with a valid stop bit -> DATA_VALID; P_DATA=0xA5.
- Start glitch: RX_IN low for 2 cycles, then high -> no pulses, FSM back in IDLE by cycle t0+8. Single-cycle glitch at the mid-bit sample of data bit 3 -> received word unaffected.
- RST asserted during data bit 4 of a frame, then a clean 0x3C frame -> no pulse from the aborted frame; 0x3C is received correctly.
